// File: rtl/aoi_sweep_ctrl.sv
// 2-2 AOI controller: manual/auto-sweep vector select, registered AOI, 4-digit scan.
// Optional macro AOI_PASS_COUNT_EN: digit 3 shows how many vectors in the last full sweep gave Y=1.
module aoi_sweep_ctrl #(
  parameter int unsigned STEP_DIV = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SWT,
  input  logic       AUTO,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       Y
);

  localparam int unsigned PW = $clog2(STEP_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 2);

  // Encoding: bit 0 set = digit slot, bits [2:1] = digit index; +1 walks the frame.
  typedef enum logic [2:0] {
    S_BLANK0 = 3'd0, S_DIG0 = 3'd1, S_BLANK1 = 3'd2, S_DIG1 = 3'd3,
    S_BLANK2 = 3'd4, S_DIG2 = 3'd5, S_BLANK3 = 3'd6, S_DIG3 = 3'd7
  } scan_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  logic [3:0]    swt_s1_q, swt_s2_q;
  logic          auto_s1_q, auto_s2_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          y_q, y_d;
  scan_e         state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    vec;
  logic          entry, step, wrap;
  logic [6:0]    dig3;

  // Entry fires as synced AUTO rises, so the counter is already 0 when V first selects it.
  assign entry = auto_s1_q & ~auto_s2_q;
  assign step  = auto_s2_q && (pre_q == PRE_LAST);
  assign wrap  = step && (cnt_q == 4'hF);
  assign vec   = auto_s2_q ? cnt_q : swt_s2_q;
  assign y_d   = ~((vec[0] & vec[1]) | (vec[2] & vec[3]));

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (entry) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (auto_s2_q) begin
      if (step) begin
        pre_d = '0;
        cnt_d = cnt_q + 4'd1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

`ifdef AOI_PASS_COUNT_EN
  logic [4:0] pass_acc_q, pass_acc_d, pass_tot;
  logic [3:0] pass_disp_q, pass_disp_d;
  logic       pass_shown_q, pass_shown_d;

  assign pass_tot = pass_acc_q + {4'b0000, y_q};

  always_comb begin
    pass_acc_d   = pass_acc_q;
    pass_disp_d  = pass_disp_q;
    pass_shown_d = pass_shown_q;
    if (entry) begin
      pass_acc_d   = '0;
      pass_disp_d  = '0;
      pass_shown_d = 1'b0;
    end else if (wrap) begin
      pass_disp_d  = pass_tot[3:0];
      pass_acc_d   = '0;
      pass_shown_d = 1'b1;
    end else if (step) begin
      pass_acc_d   = pass_tot;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pass_acc_q   <= '0;
      pass_disp_q  <= '0;
      pass_shown_q <= 1'b0;
    end else begin
      pass_acc_q   <= pass_acc_d;
      pass_disp_q  <= pass_disp_d;
      pass_shown_q <= pass_shown_d;
    end
  end

  assign dig3 = pass_shown_q ? hex_glyph(pass_disp_q) : 7'b1111111;
`else
  assign dig3 = 7'b1111111;
`endif

  // AN follows state_q one cycle late, so SEG settles during the all-off cycle.
  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    an_d    = 4'b1111;
    seg_d   = seg_q;
    if (!state_q[0]) begin
      state_d = scan_e'(state_q + 3'd1);
      scan_d  = '0;
      case (state_q[2:1])
        2'd0:    seg_d = y_q ? 7'b1111001 : 7'b1000000;
        2'd1:    seg_d = hex_glyph(vec);
        2'd2:    seg_d = auto_s2_q ? 7'b0001000 : 7'b0111111;
        default: seg_d = dig3;
      endcase
    end else begin
      an_d[state_q[2:1]] = 1'b0;
      if (scan_q == SCAN_LAST) begin
        state_d = scan_e'(state_q + 3'd1);
        scan_d  = '0;
      end else begin
        scan_d  = scan_q + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      swt_s1_q  <= '0;
      swt_s2_q  <= '0;
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
      cnt_q     <= '0;
      pre_q     <= '0;
      y_q       <= 1'b1;
      state_q   <= S_BLANK0;
      scan_q    <= '0;
      seg_q     <= '1;
      an_q      <= '1;
    end else begin
      swt_s1_q  <= SWT;
      swt_s2_q  <= swt_s1_q;
      auto_s1_q <= AUTO;
      auto_s2_q <= auto_s1_q;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      y_q       <= y_d;
      state_q   <= state_d;
      scan_q    <= scan_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign Y   = y_q;

endmodule
